// File: rtl/jstk_poller_pkg.sv
// Shared types and constants for the PMOD joystick poller: FSM encoding, LED command
// opcode, receive-byte offsets and small word helpers.
package jstk_poller_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StBusy = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [5:0] JstkCmdLed = 6'b100000;

  // Byte offsets into the 40-bit receive word; byte 0 is the first received (bits 39:32).
  localparam int unsigned XLoByte = 0;
  localparam int unsigned XHiByte = 1;
  localparam int unsigned YLoByte = 2;
  localparam int unsigned YHiByte = 3;
  localparam int unsigned BtnByte = 4;

  function automatic logic [7:0] rx_byte(input logic [39:0] word, input int unsigned idx);
    logic [39:0] sh;
    sh = word >> (8 * (4 - idx));
    return sh[7:0];
  endfunction

  function automatic logic [39:0] led_cmd(input logic [1:0] leds);
    return {JstkCmdLed, leds, 32'h0};
  endfunction

endpackage

// File: rtl/jstk_poller_if.sv
// Handshake between the poller (master modport) and the 40-bit SPI master (slave modport).
interface jstk_poller_if;
  logic        spi_trigger;
  logic [39:0] spi_out_bytes;
  logic [39:0] spi_in_bytes;
  logic        spi_cs;

  modport master (
    output spi_trigger,
    output spi_out_bytes,
    input  spi_in_bytes,
    input  spi_cs
  );

  modport slave (
    input  spi_trigger,
    input  spi_out_bytes,
    output spi_in_bytes,
    output spi_cs
  );
endinterface

// File: rtl/jstk_poller_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset to a configurable value.
module jstk_poller_sync_2ff #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/jstk_poller.sv
// Periodic PMOD joystick poller: triggers the SPI master every PERIOD clocks, tracks the
// transfer through the synchronized chip select and decodes position and buttons.
module jstk_poller
  import jstk_poller_pkg::*;
#(
  parameter int unsigned PERIOD  = 1_000_000,
  parameter int unsigned TIMEOUT = 20_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           leds,
  jstk_poller_if.master        spi,
  output logic [9:0]           x,
  output logic [9:0]           y,
  output logic [2:0]           buttons,
  output logic                 sample_valid,
  output logic                 timeout_err
);

  localparam int unsigned PerW = $clog2(PERIOD);
  localparam int unsigned TimW = $clog2(TIMEOUT);

  state_e          state_q, state_d;
  logic [PerW-1:0] per_cnt_q, per_cnt_d;
  logic            poll_due_q, poll_due_d;
  logic [TimW-1:0] wdog_q, wdog_d;
  logic [1:0]      leds_q, leds_d;
  logic            trig_q, trig_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [2:0]      btn_q, btn_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            cs_s;
  logic            per_wrap, wdog_expired;

  logic [7:0] x_lo, x_hi, y_lo, y_hi, btn_b;
  logic       unused_rx_bits;

  jstk_poller_sync_2ff #(
    .ResetValue (1'b1)
  ) u_cs_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (spi.spi_cs),
    .q_o   (cs_s)
  );

  assign x_lo  = rx_byte(spi.spi_in_bytes, XLoByte);
  assign x_hi  = rx_byte(spi.spi_in_bytes, XHiByte);
  assign y_lo  = rx_byte(spi.spi_in_bytes, YLoByte);
  assign y_hi  = rx_byte(spi.spi_in_bytes, YHiByte);
  assign btn_b = rx_byte(spi.spi_in_bytes, BtnByte);
  // Upper bits of the high bytes carry no position information.
  assign unused_rx_bits = ^{x_hi[7:2], y_hi[7:2], btn_b[7:3]};

  assign per_wrap     = (per_cnt_q == PerW'(PERIOD - 1));
  assign wdog_expired = (wdog_q == TimW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_wrap ? '0 : per_cnt_q + 1'b1;
    poll_due_d = poll_due_q | per_wrap;
    wdog_d     = wdog_q;
    leds_d     = leds_q;
    trig_d     = trig_q;
    x_d        = x_q;
    y_d        = y_q;
    btn_d      = btn_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        if (poll_due_q && enable) begin
          state_d    = StReq;
          poll_due_d = 1'b0;
          wdog_d     = '0;
          leds_d     = leds;
          trig_d     = 1'b1;
        end
      end
      StReq: begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_expired) begin
          state_d = StIdle;
          trig_d  = 1'b0;
          err_d   = 1'b1;
        end else if (!cs_s) begin
          state_d = StBusy;
          trig_d  = 1'b0;
        end
      end
      StBusy: begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_expired) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (cs_s) begin
          // Outputs load on the way into DONE so the pulse lands in the DONE cycle.
          state_d = StDone;
          x_d     = {x_hi[1:0], x_lo};
          y_d     = {y_hi[1:0], y_lo};
          btn_d   = btn_b[2:0];
          valid_d = 1'b1;
          err_d   = 1'b0;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      per_cnt_q  <= '0;
      poll_due_q <= 1'b0;
      wdog_q     <= '0;
      leds_q     <= '0;
      trig_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      btn_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      poll_due_q <= poll_due_d;
      wdog_q     <= wdog_d;
      leds_q     <= leds_d;
      trig_q     <= trig_d;
      x_q        <= x_d;
      y_q        <= y_d;
      btn_q      <= btn_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign spi.spi_trigger   = trig_q;
  assign spi.spi_out_bytes = led_cmd(leds_q);
  assign x                 = x_q;
  assign y                 = y_q;
  assign buttons           = btn_q;
  assign sample_valid      = valid_q;
  assign timeout_err       = err_q;

endmodule

// File: doc/jstk_poller.md
# jstk_poller

Periodic transaction controller for the 40-bit SPI master that talks to the PMOD joystick. It starts a transfer every `PERIOD` clocks and holds the master's trigger until the transfer is under way. It detects completion from the master's chip-select and decodes the five received bytes into X/Y position and button state. It sits between the SPI master and the game logic (paddle control), on the 50 MHz system clock.

## Interface
Parameters:
- `PERIOD`, 1_000_000: clocks between poll starts (20 ms at 50 MHz); legal minimum `TIMEOUT`+8.
- `TIMEOUT`, 20_000: max clocks spent in REQ or BUSY before abort; must exceed one full transfer (≈10.8k clocks).

Ports:
- `clk`  in  1  50 MHz system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  polling allowed; sampled only in IDLE.
- `leds`  in  2  LED command bits, captured at poll start.
- `spi_trigger`  out  1  trigger to SPI master.
- `spi_out_bytes`  out  40  transmit word to SPI master.
- `spi_in_bytes`  in  40  receive word from SPI master.
- `spi_cs`  in  1  master's active-low chip select; asynchronous to `clk` edges, synchronized internally.
- `x`  out  10  joystick X, 0..1023.
- `y`  out  10  joystick Y, 0..1023.
- `buttons`  out  3  {btn2, btn1, trigger_btn}.
- `sample_valid`  out  1  one-cycle pulse when x/y/buttons update.
- `timeout_err`  out  1  sticky abort flag.

## Operation
- `spi_cs` passes through a 2-flop synchronizer (reset value 1) giving `cs_s`. All FSM decisions use `cs_s`.
- Period counter counts 0..`PERIOD`-1 and wraps, running whenever reset is low. Its wrap sets `poll_due`; `poll_due` is cleared on entering REQ.
- Only one pending poll is kept. Wraps while busy do not queue.
- FSM states:
  - IDLE: if `poll_due` and `enable`, capture `leds` and go to REQ.
  - REQ: `spi_trigger`=1. When `cs_s`=0, go to BUSY.
  - BUSY: `spi_trigger`=0. When `cs_s`=1, go to DONE.
  - DONE: capture `spi_in_bytes`, update outputs, pulse `sample_valid`, clear `timeout_err`, go to IDLE.
- Timeout: a watchdog counter clears on entering REQ and increments in REQ and BUSY. At `TIMEOUT`-1 the FSM goes to IDLE, sets `spi_trigger`=0 and `timeout_err`=1. Outputs are not updated.
- `spi_out_bytes` = {6'b100000, leds_q, 32'h0}; byte 0 is sent first (bits 39:32).
- Decode from `spi_in_bytes` (first received byte at [39:32]):
  - x = {[25:24], [39:32]}
  - y = {[9:8], [23:16]}
  - buttons = [2:0]
  - Upper bits of the high bytes are ignored.

## Timing
- Reset values: `spi_trigger`=0, `spi_out_bytes`=40'h80_0000_0000, `x`=0, `y`=0, `buttons`=0, `sample_valid`=0, `timeout_err`=0. State=IDLE, `poll_due`=0, both counters 0.
- Reset asserted mid-transfer: FSM returns to IDLE immediately and `spi_trigger` drops asynchronously. The SPI master is left to finish on its own. Because the next poll is at least `PERIOD` away, no overlap occurs.
- `spi_trigger` and `spi_out_bytes` are registered. `spi_trigger` rises in the cycle after IDLE→REQ and stays high for at least 3 clocks (2-flop sync latency plus 1). This covers the master's slow-clock sampling because its release is gated on observed `cs_s`=0.
- `spi_out_bytes` is stable from REQ entry until the next REQ.
- Completion latency: `sample_valid` is asserted 3 clocks after the `spi_cs` rising edge (2 sync + 1 DONE). x/y/buttons change in that same cycle and hold until the next DONE.
- Simultaneous period wrap and DONE: `poll_due` is set and the next poll starts from IDLE on the following cycle.
- `enable` low: due polls remain pending until `enable` goes high.

## Structure
- Shared header `jstk_defs.vh`:
  - state encodings (IDLE=0, REQ=1, BUSY=2, DONE=3)
  - `JSTK_CMD_LED` = 6'b100000
  - byte-offset constants for X_LO, X_HI, Y_LO, Y_HI, BTN
- One sub-module: `sync_2ff`, a 2-flop synchronizer with an async reset and a reset-value parameter, used for `spi_cs`.

## Test plan
- Bench model of the master: `spi_cs` goes low 300 clocks after trigger rises, returns high 10_240 clocks later with `spi_in_bytes`=40'h34_03_C8_01_05. Expect `sample_valid` pulse with x=0x334 and y=0x1C8.
- Same model returning buttons byte 0x05: expect buttons=3'b101, checked for exactly one pulse per poll.
- `leds`=2'b10 at poll start, then changed mid-transfer: expect `spi_out_bytes`=40'h82_0000_0000 for the whole transaction.
- `spi_cs` never falls: expect `spi_trigger` to drop and `timeout_err`=1 at `TIMEOUT` clocks with x/y unchanged. A following good poll clears `timeout_err`.
- `enable`=0 across three period wraps, then set to 1: expect exactly one REQ, and polls resuming at `PERIOD` spacing.
- Assert `reset` during BUSY: expect all outputs back to reset values within the same cycle, and the next poll only after a full `PERIOD`.
